conf_pkt_host: RTL and testbench
================================

Name: conf_pkt_host

Overview:
Host-side initiator for the CPU configuration protocol. It turns a simple command stream into 134-bit request packets: write-sel, read-sel, write-program bursts and read-program. It also parses the returned response packets (ethertypes 0x9002 and 0x9004) into a response strobe. It sits between a host or test controller and the packet link that feeds the core's configuration receiver.

Parameters:
MAX_BURST, 16, depth of the write-program burst buffer (maximum words per WR_PROG packet).
MAX_OUTSTANDING, 4, maximum read requests awaiting a response.
DMAC, 48'h1111_2222_4444, destination MAC placed in request heads.
SMAC, 48'h1111_2222_3333, source MAC placed in request heads.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  0 RD_PROG, 1 WR_SEL, 2 RD_SEL, 3 WR_PROG
cmd_addr  in  32  program address (RD_PROG/WR_PROG)
cmd_wdata  in  32  write data; bit0 = sel value for WR_SEL
cmd_last  in  1  closes a WR_PROG burst
tx_valid  out  1  request flit valid; no backpressure
tx_data  out  134  request flit
rx_valid  in  1  response flit valid; bubbles allowed
rx_data  in  134  response flit
rsp_valid  out  1  one-cycle response strobe
rsp_is_prog  out  1  1 = program read (0x9004), 0 = sel read (0x9002)
rsp_addr  out  32  returned address
rsp_data  out  32  returned data
rsp_sel  out  1  returned running-mode bit
rd_outstanding  out  3  reads in flight
rx_drop_cnt  out  16  non-config packets dropped, saturating

Behaviour:
- Reset (resetn async, active-low; clock clk): all outputs 0, both FSMs idle, burst FIFO emptied. Reset mid-packet truncates the packet; the next transmission starts with a fresh head.
- Flit format:
  - [133:132] tag: 01 head, 00 body, 10 tail. [131:128] = 4'hf always.
  - Head: [127:80] DMAC, [79:32] SMAC, [31:16] = 16'h9000 | op, [15:0] = 0.
  - Non-head flits: [127:80] = 0.
- TX FSM states: T_IDLE, T_COLLECT, T_HEAD, T_BODY, T_PAD, T_TAIL.
  - Once a packet starts, tx_valid stays high on consecutive cycles through the tail. The receiver tolerates no bubbles.
- Read admission: in T_IDLE, cmd_ready = 1, except that read ops see 0 while rd_outstanding == MAX_OUTSTANDING.
- Single ops (WR_SEL, RD_SEL, RD_PROG):
  - Accept in cycle t; emit head at t+1, payload at t+2, pad (00, zero) at t+3, tail (10, zero) at t+4; back to T_IDLE at t+5.
  - Payload for WR_SEL: bit16 = cmd_wdata[0].
  - Payload for RD_PROG: [47:16] = addr.
  - Payload for RD_SEL: zero.
- WR_PROG:
  - Accepted words {addr, wdata} are pushed into the FIFO; the FSM enters T_COLLECT.
  - In T_COLLECT, cmd_ready = (cmd_op == 3).
  - The burst closes on the first of:
    - accepted cmd_last;
    - the push that makes the FIFO reach MAX_BURST;
    - a non-WR_PROG cmd_valid (not accepted; it is served afterwards).
  - On close, the FSM moves to T_HEAD on the next cycle. It then emits N data flits on consecutive cycles: [47:16] addr, [79:48] wdata. The Nth flit carries tag 10. No pad flit follows.
  - A burst of 1 word gives head + a single tail-tagged data flit.
- Outstanding counter: +1 on accepted RD_SEL/RD_PROG, -1 on rsp_valid. Both in the same cycle leave it unchanged. It never goes below 0.
- RX FSM states: R_IDLE, R_BODY, R_SKIP.
  - Head with [31:16] = 9002 or 9004 → R_BODY; any other head → R_SKIP and rx_drop_cnt + 1.
  - R_BODY, first valid body flit:
    - capture rsp_sel = [16], rsp_addr = [47:16], rsp_data = [79:48];
    - rsp_valid pulses on the next cycle;
    - go to R_IDLE if this flit is a tail, else R_SKIP.
  - R_SKIP waits for tag 10, then R_IDLE.
  - Flits with rx_valid = 0 are ignored in every state.
  - A head-tagged flit in R_BODY/R_SKIP restarts parsing as a new head.

Decomposition:
- Package conf_pkt_pkg holds:
  - op codes;
  - ethertype base 16'h9000 and response types 16'h9002 / 16'h9004;
  - tag constants HEAD/BODY/TAIL;
  - byte-valid 4'hf;
  - MAC defaults.
- One sub-module, conf_burst_fifo: synchronous 64-bit FIFO, depth MAX_BURST, with count output. TX and RX FSMs stay in the top module.

Test Plan:
- WR_SEL, wdata = 1, accepted at t → tx at t+1..t+4 with head [31:16] = 9001, flit1 bit16 = 1, flit4 tag 10, tx_valid continuous.
- WR_PROG ×3 (addr 0x0,0x4,0x8; data 0xA,0xB,0xC; last on third) → head 9003, then 3 flits with [47:16]/[79:48] matching, third tagged 10, no pad.
- 17 WR_PROG without cmd_last, MAX_BURST = 16 → first packet has 16 data flits; the 17th word starts a new burst.
- RD_PROG addr 0x100 → request flit1 [47:16] = 0x100; inject response head 9004 with body [47:16] = 0x100, [79:48] = 0xDEADBEEF → rsp_valid = 1, rsp_is_prog = 1, rsp_data = 0xDEADBEEF; rd_outstanding 1 → 0.
- 4 RD_SEL with no responses → 5th read sees cmd_ready = 0; a WR_SEL is still accepted. Response with bit16 = 1 and bubbles between flits → rsp_sel = 1, counter 3.
- Rx head with ethertype 0x0800 → no rsp_valid, rx_drop_cnt = 1. Assert resetn low mid-TX → tx_valid = 0 immediately; the next command emits a fresh head.

Source files
------------

// File: rtl/conf_pkt_pkg.sv
// Shared definitions for the CPU configuration packet host: op codes, flit tags,
// ethertypes, MAC defaults, FSM state types and flit builder helpers.
package conf_pkt_pkg;

   localparam int unsigned FLIT_W    = 134;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned ENTRY_W   = 64;
   localparam int unsigned PAYLOAD_W = 80;
   localparam int unsigned DROP_W    = 16;

   typedef enum logic [1:0] {
      OP_RD_PROG = 2'd0,
      OP_WR_SEL  = 2'd1,
      OP_RD_SEL  = 2'd2,
      OP_WR_PROG = 2'd3
   } op_e;

   localparam logic [1:0]  TAG_HEAD   = 2'b01;
   localparam logic [1:0]  TAG_BODY   = 2'b00;
   localparam logic [1:0]  TAG_TAIL   = 2'b10;
   localparam logic [3:0]  BYTE_VALID = 4'hf;

   localparam logic [15:0] ETH_BASE     = 16'h9000;
   localparam logic [15:0] ETH_RSP_SEL  = 16'h9002;
   localparam logic [15:0] ETH_RSP_PROG = 16'h9004;

   localparam logic [47:0] DMAC_DEF = 48'h1111_2222_4444;
   localparam logic [47:0] SMAC_DEF = 48'h1111_2222_3333;

   typedef enum logic [2:0] {
      T_IDLE, T_COLLECT, T_HEAD, T_BODY, T_PAD, T_TAIL
   } tx_state_e;

   typedef enum logic [1:0] {
      R_IDLE, R_BODY, R_SKIP
   } rx_state_e;

   // One buffered write-program word
   typedef struct packed {
      logic [WORD_W-1:0] wdata;
      logic [WORD_W-1:0] addr;
   } burst_word_t;

   function automatic logic [FLIT_W-1:0] mk_head(input logic [1:0]  op,
                                                 input logic [47:0] dmac,
                                                 input logic [47:0] smac);
      return {TAG_HEAD, BYTE_VALID, dmac, smac, ETH_BASE | {14'd0, op}, 16'd0};
   endfunction

   function automatic logic [FLIT_W-1:0] mk_flit(input logic [1:0]           tag,
                                                 input logic [PAYLOAD_W-1:0] low);
      return {tag, BYTE_VALID, 48'd0, low};
   endfunction

endpackage

// File: rtl/conf_burst_fifo.sv
// Single-clock FIFO buffering write-program words until a burst is closed.
// Ports: i_push/i_wdata write side, i_pop read side, o_rdata_c shows the
// oldest entry combinationally, o_count is the registered occupancy.
module conf_burst_fifo
   import conf_pkt_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               i_push,
   input  logic [ENTRY_W-1:0] i_wdata,
   input  logic               i_pop,
   output logic [ENTRY_W-1:0] o_rdata_c,
   output logic [CNT_W-1:0]   o_count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign w_do_push = i_push && (r_count != CNT_W'(DEPTH));
   assign w_do_pop  = i_pop  && (r_count != '0);

   // Pointers and occupancy
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
         if (w_do_pop)
            r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata_c = r_mem[r_rd_ptr];
   assign o_count   = r_count;

endmodule

// File: rtl/conf_pkt_host.sv
// Host-side initiator for the CPU configuration protocol. Builds request packets
// (WR_SEL, RD_SEL, RD_PROG, WR_PROG bursts) and parses response packets.
// Ports: cmd_* command stream (valid/ready), tx_* request flits (no backpressure),
// rx_* response flits, rsp_* parsed response strobe, rd_outstanding reads in
// flight, rx_drop_cnt saturating count of non-config packets dropped.
module conf_pkt_host
   import conf_pkt_pkg::*;
#(
   parameter int unsigned MAX_BURST       = 16,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter logic [47:0] DMAC            = DMAC_DEF,
   parameter logic [47:0] SMAC            = SMAC_DEF
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [WORD_W-1:0]  cmd_addr,
   input  logic [WORD_W-1:0]  cmd_wdata,
   input  logic               cmd_last,
   output logic               tx_valid,
   output logic [FLIT_W-1:0]  tx_data,
   input  logic               rx_valid,
   input  logic [FLIT_W-1:0]  rx_data,
   output logic               rsp_valid,
   output logic               rsp_is_prog,
   output logic [WORD_W-1:0]  rsp_addr,
   output logic [WORD_W-1:0]  rsp_data,
   output logic               rsp_sel,
   output logic [2:0]         rd_outstanding,
   output logic [DROP_W-1:0]  rx_drop_cnt
);

   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
   localparam int unsigned OUT_W = 3;

   // ---------------- TX path ----------------
   tx_state_e              r_tx_state, w_tx_state_d;
   logic [1:0]             r_op, w_op_d;
   logic [PAYLOAD_W-1:0]   r_payload, w_payload_d;
   logic                   r_burst, w_burst_d;
   logic                   r_tx_valid, w_tx_valid_d;
   logic [FLIT_W-1:0]      r_tx_data, w_tx_data_d;
   logic                   w_cmd_ready;
   logic                   w_push, w_pop;
   logic [ENTRY_W-1:0]     w_fifo_rdata;
   logic [CNT_W-1:0]       w_fifo_count;
   burst_word_t            w_head_word;
   burst_word_t            w_push_word;
   logic [FLIT_W-1:0]      w_burst_flit;
   logic                   w_is_read;
   logic                   w_close_on_push;
   logic [OUT_W-1:0]       r_rd_out;

   assign w_push_word     = '{wdata: cmd_wdata, addr: cmd_addr};
   assign w_head_word     = burst_word_t'(w_fifo_rdata);
   assign w_is_read       = (cmd_op == OP_RD_PROG) || (cmd_op == OP_RD_SEL);
   assign w_close_on_push = cmd_last || (w_fifo_count == CNT_W'(MAX_BURST - 1));
   // The last buffered word goes out tail-tagged
   assign w_burst_flit    = mk_flit((w_fifo_count == CNT_W'(1)) ? TAG_TAIL : TAG_BODY,
                                    {w_head_word.wdata, w_head_word.addr, 16'd0});

   conf_burst_fifo #(
      .DEPTH (MAX_BURST),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .i_push    (w_push),
      .i_wdata   (w_push_word),
      .i_pop     (w_pop),
      .o_rdata_c (w_fifo_rdata),
      .o_count   (w_fifo_count)
   );

   // TX state and registered flit output
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_tx_state <= T_IDLE;
         r_op       <= '0;
         r_payload  <= '0;
         r_burst    <= 1'b0;
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
      end else begin
         r_tx_state <= w_tx_state_d;
         r_op       <= w_op_d;
         r_payload  <= w_payload_d;
         r_burst    <= w_burst_d;
         r_tx_valid <= w_tx_valid_d;
         r_tx_data  <= w_tx_data_d;
      end
   end

   // TX next state; w_tx_*_d is the flit presented while in w_tx_state_d
   always_comb begin
      w_tx_state_d = r_tx_state;
      w_op_d       = r_op;
      w_payload_d  = r_payload;
      w_burst_d    = r_burst;
      w_tx_valid_d = 1'b0;
      w_tx_data_d  = '0;
      w_cmd_ready  = 1'b0;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      case (r_tx_state)
         T_IDLE: begin
            w_cmd_ready = !(w_is_read && (r_rd_out == OUT_W'(MAX_OUTSTANDING)));
            if (cmd_valid && w_cmd_ready) begin
               w_op_d = cmd_op;
               if (cmd_op == OP_WR_PROG) begin
                  w_push    = 1'b1;
                  w_burst_d = 1'b1;
                  if (w_close_on_push) begin
                     w_tx_state_d = T_HEAD;
                     w_tx_valid_d = 1'b1;
                     w_tx_data_d  = mk_head(OP_WR_PROG, DMAC, SMAC);
                  end else begin
                     w_tx_state_d = T_COLLECT;
                  end
               end else begin
                  w_burst_d = 1'b0;
                  case (cmd_op)
                     OP_WR_SEL:  w_payload_d = {63'd0, cmd_wdata[0], 16'd0};
                     OP_RD_PROG: w_payload_d = {32'd0, cmd_addr, 16'd0};
                     default:    w_payload_d = '0;
                  endcase
                  w_tx_state_d = T_HEAD;
                  w_tx_valid_d = 1'b1;
                  w_tx_data_d  = mk_head(cmd_op, DMAC, SMAC);
               end
            end
         end
         T_COLLECT: begin
            // Only more burst words are accepted; any other command closes the burst
            w_cmd_ready = (cmd_op == OP_WR_PROG);
            if (cmd_valid) begin
               if (cmd_op == OP_WR_PROG) begin
                  w_push = 1'b1;
                  if (w_close_on_push) begin
                     w_tx_state_d = T_HEAD;
                     w_tx_valid_d = 1'b1;
                     w_tx_data_d  = mk_head(OP_WR_PROG, DMAC, SMAC);
                  end
               end else begin
                  w_tx_state_d = T_HEAD;
                  w_tx_valid_d = 1'b1;
                  w_tx_data_d  = mk_head(OP_WR_PROG, DMAC, SMAC);
               end
            end
         end
         T_HEAD: begin
            w_tx_state_d = T_BODY;
            w_tx_valid_d = 1'b1;
            if (r_burst) begin
               w_pop       = 1'b1;
               w_tx_data_d = w_burst_flit;
            end else begin
               w_tx_data_d = mk_flit(TAG_BODY, r_payload);
            end
         end
         T_BODY: begin
            if (r_burst) begin
               if (w_fifo_count == '0) begin
                  w_tx_state_d = T_IDLE;
               end else begin
                  w_pop        = 1'b1;
                  w_tx_valid_d = 1'b1;
                  w_tx_data_d  = w_burst_flit;
               end
            end else begin
               w_tx_state_d = T_PAD;
               w_tx_valid_d = 1'b1;
               w_tx_data_d  = mk_flit(TAG_BODY, '0);
            end
         end
         T_PAD: begin
            w_tx_state_d = T_TAIL;
            w_tx_valid_d = 1'b1;
            w_tx_data_d  = mk_flit(TAG_TAIL, '0);
         end
         T_TAIL: begin
            w_tx_state_d = T_IDLE;
         end
         default: begin
            w_tx_state_d = T_IDLE;
         end
      endcase
   end

   // ---------------- RX path ----------------
   rx_state_e              r_rx_state, w_rx_state_d;
   logic                   r_rx_prog, w_rx_prog_d;
   logic                   r_rsp_valid, w_rsp_valid_d;
   logic                   r_rsp_is_prog, w_rsp_is_prog_d;
   logic [WORD_W-1:0]      r_rsp_addr, w_rsp_addr_d;
   logic [WORD_W-1:0]      r_rsp_data, w_rsp_data_d;
   logic                   r_rsp_sel, w_rsp_sel_d;
   logic [DROP_W-1:0]      r_drop, w_drop_d;
   logic [1:0]             w_rx_tag;
   logic [15:0]            w_rx_eth;
   logic                   w_rx_unused;

   assign w_rx_tag    = rx_data[133:132];
   assign w_rx_eth    = rx_data[31:16];
   assign w_rx_unused = ^{rx_data[131:80], rx_data[15:0]};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rx_state    <= R_IDLE;
         r_rx_prog     <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_is_prog <= 1'b0;
         r_rsp_addr    <= '0;
         r_rsp_data    <= '0;
         r_rsp_sel     <= 1'b0;
         r_drop        <= '0;
      end else begin
         r_rx_state    <= w_rx_state_d;
         r_rx_prog     <= w_rx_prog_d;
         r_rsp_valid   <= w_rsp_valid_d;
         r_rsp_is_prog <= w_rsp_is_prog_d;
         r_rsp_addr    <= w_rsp_addr_d;
         r_rsp_data    <= w_rsp_data_d;
         r_rsp_sel     <= w_rsp_sel_d;
         r_drop        <= w_drop_d;
      end
   end

   // RX parser; a head flit restarts parsing from any state
   always_comb begin
      w_rx_state_d    = r_rx_state;
      w_rx_prog_d     = r_rx_prog;
      w_rsp_valid_d   = 1'b0;
      w_rsp_is_prog_d = r_rsp_is_prog;
      w_rsp_addr_d    = r_rsp_addr;
      w_rsp_data_d    = r_rsp_data;
      w_rsp_sel_d     = r_rsp_sel;
      w_drop_d        = r_drop;
      if (rx_valid) begin
         if (w_rx_tag == TAG_HEAD) begin
            if ((w_rx_eth == ETH_RSP_SEL) || (w_rx_eth == ETH_RSP_PROG)) begin
               w_rx_state_d = R_BODY;
               w_rx_prog_d  = (w_rx_eth == ETH_RSP_PROG);
            end else begin
               w_rx_state_d = R_SKIP;
               if (r_drop != {DROP_W{1'b1}})
                  w_drop_d = r_drop + DROP_W'(1);
            end
         end else begin
            case (r_rx_state)
               R_BODY: begin
                  w_rsp_valid_d   = 1'b1;
                  w_rsp_is_prog_d = r_rx_prog;
                  w_rsp_sel_d     = rx_data[16];
                  w_rsp_addr_d    = rx_data[47:16];
                  w_rsp_data_d    = rx_data[79:48];
                  w_rx_state_d    = (w_rx_tag == TAG_TAIL) ? R_IDLE : R_SKIP;
               end
               R_SKIP: begin
                  if (w_rx_tag == TAG_TAIL)
                     w_rx_state_d = R_IDLE;
               end
               default: begin
                  w_rx_state_d = R_IDLE;
               end
            endcase
         end
      end
   end

   // Reads in flight: +1 per accepted read, -1 per response strobe
   logic w_rd_inc, w_rd_dec;
   assign w_rd_inc = (r_tx_state == T_IDLE) && cmd_valid && w_cmd_ready && w_is_read;
   assign w_rd_dec = r_rsp_valid && (r_rd_out != '0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         r_rd_out <= '0;
      else if (w_rd_inc && !w_rd_dec)
         r_rd_out <= r_rd_out + OUT_W'(1);
      else if (w_rd_dec && !w_rd_inc)
         r_rd_out <= r_rd_out - OUT_W'(1);
   end

   assign cmd_ready      = w_cmd_ready;
   assign tx_valid       = r_tx_valid;
   assign tx_data        = r_tx_data;
   assign rsp_valid      = r_rsp_valid;
   assign rsp_is_prog    = r_rsp_is_prog;
   assign rsp_addr       = r_rsp_addr;
   assign rsp_data       = r_rsp_data;
   assign rsp_sel        = r_rsp_sel;
   assign rd_outstanding = r_rd_out;
   assign rx_drop_cnt    = r_drop;

endmodule

// File: tb/tb_conf_pkt_host.sv
// Directed self-checking bench for conf_pkt_host.
module tb_conf_pkt_host;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'd0;
   logic [31:0]   cmd_addr = '0;
   logic [31:0]   cmd_wdata = '0;
   logic          cmd_last = 1'b0;
   logic          tx_valid;
   logic [133:0]  tx_data;
   logic          rx_valid = 1'b0;
   logic [133:0]  rx_data = '0;
   logic          rsp_valid;
   logic          rsp_is_prog;
   logic [31:0]   rsp_addr;
   logic [31:0]   rsp_data;
   logic          rsp_sel;
   logic [2:0]    rd_outstanding;
   logic [15:0]   rx_drop_cnt;

   int errors = 0;
   int checks = 0;

   conf_pkt_host dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_last(cmd_last),
      .tx_valid(tx_valid), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_data(rx_data),
      .rsp_valid(rsp_valid), .rsp_is_prog(rsp_is_prog), .rsp_addr(rsp_addr),
      .rsp_data(rsp_data), .rsp_sel(rsp_sel),
      .rd_outstanding(rd_outstanding), .rx_drop_cnt(rx_drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [133:0] hd(input logic [15:0] eth);
      return {2'b01, 4'hf, 48'h1111_2222_4444, 48'h1111_2222_3333, eth, 16'h0000};
   endfunction

   function automatic logic [133:0] fl(input logic [1:0] tag, input logic [79:0] low);
      return {tag, 4'hf, 48'd0, low};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one command and hold it until accepted; returns one cycle after acceptance
   task automatic issue(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic last);
      int n;
      n = 0;
      cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_last = last;
      cmd_valid = 1'b1;
      #1;
      while (cmd_ready !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue_ready op=%0d: cmd_ready=%b required 1", op, cmd_ready);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_last  = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      #12;
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      checks++; if (tx_data !== '0) begin errors++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
      checks++; if (rsp_valid !== 1'b0 || rsp_addr !== '0 || rsp_data !== '0 || rsp_sel !== 1'b0 || rsp_is_prog !== 1'b0) begin
         errors++; $display("FAIL reset_rsp: valid=%b addr=%h data=%h sel=%b prog=%b want all 0", rsp_valid, rsp_addr, rsp_data, rsp_sel, rsp_is_prog);
      end
      checks++; if (rd_outstanding !== 3'd0 || rx_drop_cnt !== 16'd0) begin
         errors++; $display("FAIL reset_counters: outstanding=%0d drop=%0d want 0/0", rd_outstanding, rx_drop_cnt);
      end
      resetn = 1'b1;
      step();
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
   endtask

   task automatic test_wr_sel();
      logic [133:0] exp [4];
      exp[0] = hd(16'h9001);
      exp[1] = fl(2'b00, 80'h1_0000);
      exp[2] = fl(2'b00, 80'h0);
      exp[3] = fl(2'b10, 80'h0);
      issue(2'd1, 32'h0, 32'h1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
            errors++; $display("FAIL wr_sel_flit%0d: valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, exp[i]);
         end
         step();
      end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL wr_sel_end: tx_valid=%b want 0", tx_valid); end
   endtask

   task automatic test_wr_prog();
      logic [31:0] a [3];
      logic [31:0] d [3];
      logic [133:0] e;
      a[0] = 32'h0; a[1] = 32'h4; a[2] = 32'h8;
      d[0] = 32'hA; d[1] = 32'hB; d[2] = 32'hC;
      for (int i = 0; i < 3; i++) issue(2'd3, a[i], d[i], (i == 2));
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== hd(16'h9003)) begin
         errors++; $display("FAIL wr_prog_head: valid=%b data=%h want %h", tx_valid, tx_data, hd(16'h9003));
      end
      for (int i = 0; i < 3; i++) begin
         step();
         e = fl((i == 2) ? 2'b10 : 2'b00, {d[i], a[i], 16'h0});
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== e) begin
            errors++; $display("FAIL wr_prog_flit%0d: valid=%b data=%h want %h", i, tx_valid, tx_data, e);
         end
      end
      step();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL wr_prog_no_pad: tx_valid=%b want 0", tx_valid); end
   endtask

   task automatic test_burst_full();
      logic [133:0] e;
      int bad;
      bad = 0;
      for (int i = 0; i < 16; i++) issue(2'd3, 32'(i * 4), 32'h100 + 32'(i), 1'b0);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== hd(16'h9003)) begin
         errors++; $display("FAIL burst_head: valid=%b data=%h want %h", tx_valid, tx_data, hd(16'h9003));
      end
      for (int i = 0; i < 16; i++) begin
         step();
         e = fl((i == 15) ? 2'b10 : 2'b00, {32'h100 + 32'(i), 32'(i * 4), 16'h0});
         if (tx_valid !== 1'b1 || tx_data !== e) begin
            bad++; $display("FAIL burst_flit%0d: valid=%b data=%h want %h", i, tx_valid, tx_data, e);
         end
      end
      checks++; if (bad != 0) errors++;
      step();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL burst_end: tx_valid=%b want 0", tx_valid); end
      // 17th word opens a new burst which a WR_SEL then closes
      issue(2'd3, 32'h40, 32'h110, 1'b0);
      step();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL burst2_collect: tx_valid=%b want 0", tx_valid); end
      cmd_op = 2'd1; cmd_wdata = 32'h0; cmd_valid = 1'b1;
      #1;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL burst2_ready: cmd_ready=%b want 0", cmd_ready); end
      step();
      checks++; if (tx_data !== hd(16'h9003)) begin errors++; $display("FAIL burst2_head: data=%h want %h", tx_data, hd(16'h9003)); end
      step();
      e = fl(2'b10, {32'h110, 32'h40, 16'h0});
      checks++; if (tx_valid !== 1'b1 || tx_data !== e) begin errors++; $display("FAIL burst2_single: valid=%b data=%h want %h", tx_valid, tx_data, e); end
      step();
      checks++; if (tx_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL burst2_idle: valid=%b ready=%b want 0/1", tx_valid, cmd_ready); end
      step();
      cmd_valid = 1'b0;
      checks++; if (tx_data !== hd(16'h9001)) begin errors++; $display("FAIL deferred_wr_sel: data=%h want %h", tx_data, hd(16'h9001)); end
      repeat (4) step();
   endtask

   task automatic test_rd_prog();
      logic [133:0] e;
      issue(2'd0, 32'h100, 32'h0, 1'b0);
      checks++; if (rd_outstanding !== 3'd1) begin errors++; $display("FAIL rd_prog_outstanding_inc: got %0d want 1", rd_outstanding); end
      checks++; if (tx_data !== hd(16'h9000)) begin errors++; $display("FAIL rd_prog_head: data=%h want %h", tx_data, hd(16'h9000)); end
      step();
      e = fl(2'b00, {32'h0, 32'h100, 16'h0});
      checks++; if (tx_data !== e) begin errors++; $display("FAIL rd_prog_flit1: data=%h want %h", tx_data, e); end
      repeat (3) step();
      rx_valid = 1'b1; rx_data = hd(16'h9004);
      step();
      rx_data = fl(2'b10, {32'hDEADBEEF, 32'h100, 16'h0});
      step();
      rx_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_is_prog !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_addr !== 32'h100) begin
         errors++; $display("FAIL rd_prog_rsp: valid=%b prog=%b addr=%h data=%h want 1/1/100/deadbeef", rsp_valid, rsp_is_prog, rsp_addr, rsp_data);
      end
      step();
      checks++; if (rsp_valid !== 1'b0 || rd_outstanding !== 3'd0) begin
         errors++; $display("FAIL rd_prog_after: valid=%b outstanding=%0d want 0/0", rsp_valid, rd_outstanding);
      end
   endtask

   task automatic test_rd_limit();
      for (int i = 0; i < 4; i++) begin
         issue(2'd2, 32'h0, 32'h0, 1'b0);
         repeat (4) step();
      end
      checks++; if (rd_outstanding !== 3'd4) begin errors++; $display("FAIL rd_limit_count: got %0d want 4", rd_outstanding); end
      cmd_op = 2'd2; cmd_valid = 1'b1;
      #1;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rd_limit_rd_sel: cmd_ready=%b want 0", cmd_ready); end
      cmd_op = 2'd0;
      #1;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rd_limit_rd_prog: cmd_ready=%b want 0", cmd_ready); end
      cmd_op = 2'd1; cmd_wdata = 32'h0;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_limit_wr_sel: cmd_ready=%b want 1", cmd_ready); end
      step();
      cmd_valid = 1'b0;
      checks++; if (tx_data !== hd(16'h9001)) begin errors++; $display("FAIL rd_limit_wr_head: data=%h want %h", tx_data, hd(16'h9001)); end
      repeat (4) step();
      // Sel response with bubbles; bubble content must be ignored
      rx_valid = 1'b1; rx_data = hd(16'h9002);
      step();
      rx_valid = 1'b0; rx_data = hd(16'h0800);
      step();
      rx_valid = 1'b1; rx_data = fl(2'b00, {32'h0, 32'h1, 16'h0});
      step();
      rx_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sel !== 1'b1 || rsp_is_prog !== 1'b0) begin
         errors++; $display("FAIL sel_rsp: valid=%b sel=%b prog=%b want 1/1/0", rsp_valid, rsp_sel, rsp_is_prog);
      end
      step();
      checks++; if (rd_outstanding !== 3'd3) begin errors++; $display("FAIL sel_rsp_count: got %0d want 3", rd_outstanding); end
      rx_valid = 1'b1; rx_data = fl(2'b10, 80'h0);
      step();
      rx_valid = 1'b0;
      checks++; if (rsp_valid !== 1'b0 || rx_drop_cnt !== 16'd0) begin
         errors++; $display("FAIL sel_rsp_tail: valid=%b drop=%0d want 0/0", rsp_valid, rx_drop_cnt);
      end
   endtask

   task automatic test_rx_drop();
      rx_valid = 1'b1; rx_data = hd(16'h0800);
      step();
      checks++; if (rx_drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_count: got %0d want 1", rx_drop_cnt); end
      rx_data = fl(2'b00, {32'h1234, 32'h5678, 16'h0});
      step();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drop_no_rsp: rsp_valid=%b want 0", rsp_valid); end
      // Head arriving while skipping restarts parsing
      rx_data = hd(16'h9004);
      step();
      rx_data = fl(2'b10, {32'hCAFE0001, 32'h200, 16'h0});
      step();
      rx_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_is_prog !== 1'b1 || rsp_data !== 32'hCAFE0001 || rsp_addr !== 32'h200) begin
         errors++; $display("FAIL restart_rsp: valid=%b prog=%b addr=%h data=%h want 1/1/200/cafe0001", rsp_valid, rsp_is_prog, rsp_addr, rsp_data);
      end
      step();
      checks++; if (rd_outstanding !== 3'd2 || rx_drop_cnt !== 16'd1) begin
         errors++; $display("FAIL restart_counts: outstanding=%0d drop=%0d want 2/1", rd_outstanding, rx_drop_cnt);
      end
   endtask

   task automatic test_reset_mid_tx();
      issue(2'd1, 32'h0, 32'h1, 1'b0);
      step();
      checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL mid_tx_active: tx_valid=%b want 1", tx_valid); end
      resetn = 1'b0;
      #1;
      checks++; if (tx_valid !== 1'b0 || tx_data !== '0) begin errors++; $display("FAIL mid_tx_reset: valid=%b data=%h want 0", tx_valid, tx_data); end
      checks++; if (rd_outstanding !== 3'd0 || rx_drop_cnt !== 16'd0) begin
         errors++; $display("FAIL mid_tx_counters: outstanding=%0d drop=%0d want 0/0", rd_outstanding, rx_drop_cnt);
      end
      #2;
      resetn = 1'b1;
      step();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_quiet: tx_valid=%b want 0", tx_valid); end
      issue(2'd2, 32'h0, 32'h0, 1'b0);
      checks++; if (tx_valid !== 1'b1 || tx_data !== hd(16'h9002)) begin
         errors++; $display("FAIL post_reset_head: valid=%b data=%h want %h", tx_valid, tx_data, hd(16'h9002));
      end
      repeat (4) step();
      checks++; if (tx_valid !== 1'b0 || rd_outstanding !== 3'd1) begin
         errors++; $display("FAIL post_reset_end: valid=%b outstanding=%0d want 0/1", tx_valid, rd_outstanding);
      end
   endtask

   initial begin
      test_reset();
      test_wr_sel();
      test_wr_prog();
      test_burst_full();
      test_rd_prog();
      test_rd_limit();
      test_rx_drop();
      test_reset_mid_tx();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
